mem_port_arbiter: RTL and testbench

Shares one SRAM-like memory port between the instruction-fetch requester (IF/PC side) and the data requester (MEM-stage bridge) of the 5-stage MIPS pipeline. It uses a req/addr_ok/data_ok handshake with one outstanding transaction. Data wins by default, with a starvation limiter for fetch. Fetch responses made stale by a pipeline flush are discarded. It exports a busy flag to the stall unit.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/mem_port_arbiter.sv | 151 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_INST = 1'b0,
    OWN_DATA = 1'b1
  } owner_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the fetch and data requesters onto one SRAM-like port with a
// single outstanding transaction, fetch starvation limiting and flush discard.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic              inst_cancel,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [1:0]        mem_size,
  output logic [3:0]        mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              arb_busy
);

  localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);
  localparam bit STARVE_EN = (STARVE_LIMIT != 0);

  arb_state_e        state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              cancel_q, cancel_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_d;
  logic [1:0]        size_d;
  logic [3:0]        wstrb_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              arb_en;
  logic              pick_inst;
  logic              done;

  // State, ownership and registered port fields
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      owner_q   <= OWN_INST;
      cancel_q  <= 1'b0;
      cnt_q     <= '0;
      mem_wr    <= 1'b0;
      mem_size  <= 2'd0;
      mem_wstrb <= 4'd0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      cancel_q  <= cancel_d;
      cnt_q     <= cnt_d;
      mem_wr    <= wr_d;
      mem_size  <= size_d;
      mem_wstrb <= wstrb_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
    end
  end

  // Next state, arbitration and grant capture
  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    cancel_d  = cancel_q;
    cnt_d     = cnt_q;
    wr_d      = mem_wr;
    size_d    = mem_size;
    wstrb_d   = mem_wstrb;
    addr_d    = mem_addr;
    wdata_d   = mem_wdata;
    arb_en    = 1'b0;
    pick_inst = 1'b0;
    done      = 1'b0;

    case (state_q)
      IDLE: arb_en = 1'b1;
      ADDR: if (mem_addr_ok) state_d = RESP;
      RESP: begin
        if (mem_data_ok) begin
          done     = 1'b1;
          arb_en   = 1'b1;
          state_d  = IDLE;
          cancel_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // A flush only marks the fetch that is actually in flight
    if (state_q != IDLE && owner_q == OWN_INST && inst_cancel && !done) begin
      cancel_d = 1'b1;
    end

    if (arb_en && (inst_req || data_req)) begin
      pick_inst = inst_req && (!data_req || (STARVE_EN && cnt_q == CNT_MAX));
      state_d   = ADDR;
      if (pick_inst) begin
        owner_d  = OWN_INST;
        cancel_d = inst_cancel;
        cnt_d    = '0;
        wr_d     = 1'b0;
        size_d   = SZ_WORD;
        wstrb_d  = 4'd0;
        addr_d   = inst_addr;
        wdata_d  = '0;
      end else begin
        owner_d  = OWN_DATA;
        cancel_d = 1'b0;
        if (inst_req && cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
        wr_d     = data_wr;
        size_d   = data_size;
        wstrb_d  = data_wstrb;
        addr_d   = data_addr;
        wdata_d  = data_wdata;
      end
    end
  end

  assign mem_req  = (state_q == ADDR);
  assign arb_busy = (state_q != IDLE);

  // Handshake returns are steered to the owner in the same cycle
  assign inst_addr_ok = mem_req && (owner_q == OWN_INST) && mem_addr_ok;
  assign data_addr_ok = mem_req && (owner_q == OWN_DATA) && mem_addr_ok;
  assign inst_data_ok = (state_q == RESP) && (owner_q == OWN_INST) && mem_data_ok && !cancel_q;
  assign data_data_ok = (state_q == RESP) && (owner_q == OWN_DATA) && mem_data_ok;
  assign inst_rdata   = inst_data_ok ? mem_rdata : '0;
  assign data_rdata   = data_data_ok ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized bench for mem_port_arbiter against a
// transaction-level reference model of the arbitration rules.
module tb_mem_port_arbiter;

  localparam int STARVE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req, inst_cancel;
  logic [31:0] inst_addr;
  logic        inst_addr_ok, inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req, data_wr;
  logic [1:0]  data_size;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr, data_wdata;
  logic        data_addr_ok, data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req, mem_wr;
  logic [1:0]  mem_size;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_addr_ok, mem_data_ok;
  logic [31:0] mem_rdata;
  logic        arb_busy;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: transaction in flight, its phase, owner and fields
  bit          m_busy, m_resp, m_inst, m_cancel;
  int          m_losses;
  logic        e_wr;
  logic [1:0]  e_size;
  logic [3:0]  e_wstrb;
  logic [31:0] e_addr, e_wdata;
  bit          acc_i, acc_d;

  mem_port_arbiter #(.STARVE_LIMIT(STARVE), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_cancel(inst_cancel),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .arb_busy(arb_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Compare all outputs with the model, then advance the model one clock
  task automatic model_cycle();
    bit done, fetch_ok, win_inst;
    acc_i = inst_addr_ok;
    acc_d = data_addr_ok;
    if (!rst) begin
      m_busy = 0; m_resp = 0; m_inst = 1; m_cancel = 0; m_losses = 0;
      e_wr = 0; e_size = 0; e_wstrb = 0; e_addr = 0; e_wdata = 0;
    end
    chk("mem_req", mem_req, m_busy && !m_resp);
    chk("arb_busy", arb_busy, m_busy);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wr", mem_wr, e_wr);
    chk("mem_size", mem_size, e_size);
    chk("mem_wstrb", mem_wstrb, e_wstrb);
    if (!m_inst || !rst) chk("mem_wdata", mem_wdata, e_wdata);
    chk("inst_addr_ok", inst_addr_ok, rst && m_busy && !m_resp && m_inst && mem_addr_ok);
    chk("data_addr_ok", data_addr_ok, rst && m_busy && !m_resp && !m_inst && mem_addr_ok);
    done = rst && m_busy && m_resp && mem_data_ok;
    fetch_ok = done && m_inst && !m_cancel;
    chk("inst_data_ok", inst_data_ok, fetch_ok);
    chk("inst_rdata", inst_rdata, fetch_ok ? mem_rdata : 32'h0);
    chk("data_data_ok", data_data_ok, done && !m_inst);
    chk("data_rdata", data_rdata, (done && !m_inst) ? mem_rdata : 32'h0);
    if (!rst) return;
    if (m_busy && m_inst && inst_cancel) m_cancel = 1;
    if (m_busy && !m_resp && mem_addr_ok) m_resp = 1;
    if (done) begin m_busy = 0; m_cancel = 0; end
    if (!m_busy && (inst_req || data_req)) begin
      win_inst = inst_req && (!data_req || (STARVE > 0 && m_losses >= STARVE));
      if (win_inst) begin
        m_losses = 0; m_cancel = inst_cancel;
        e_wr = 0; e_size = 2'd2; e_wstrb = 0; e_addr = inst_addr;
      end else begin
        if (inst_req) m_losses++;
        m_cancel = 0;
        e_wr = data_wr; e_size = data_size; e_wstrb = data_wstrb;
        e_addr = data_addr; e_wdata = data_wdata;
      end
      m_busy = 1; m_resp = 0; m_inst = win_inst;
    end
  endtask

  task automatic tick();
    #1;
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 0; inst_req = 0; inst_addr = 0; inst_cancel = 0;
    data_req = 0; data_wr = 0; data_size = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    tick();
    #1 chk("rst_mem_req", mem_req, 0); chk("rst_busy", arb_busy, 0);
    chk("rst_mem_wdata", mem_wdata, 0); chk("rst_mem_addr", mem_addr, 0);
    tick();
    rst = 1;
    tick();

    // Single fetch with address accept after 2 cycles, data 3 cycles later
    inst_req = 1; inst_addr = 32'hBFC0_0000;
    #1 chk("fetch_idle_req", mem_req, 0);
    tick();
    #1 chk("fetch_mem_req", mem_req, 1); chk("fetch_addr", mem_addr, 32'hBFC0_0000);
    chk("fetch_size", mem_size, 2);
    tick();
    mem_addr_ok = 1;
    #1 chk("fetch_addr_ok", inst_addr_ok, 1);
    tick();
    inst_req = 0; mem_addr_ok = 0;
    #1 chk("fetch_resp_req", mem_req, 0);
    tick();
    tick();
    mem_data_ok = 1; mem_rdata = 32'h3C08_0001;
    #1 chk("fetch_data_ok", inst_data_ok, 1); chk("fetch_rdata", inst_rdata, 32'h3C08_0001);
    tick();
    mem_data_ok = 0;
    #1 chk("fetch_done_busy", arb_busy, 0);
    tick();

    // Protocol noise in IDLE
    mem_data_ok = 1; mem_addr_ok = 1; mem_rdata = 32'h1234_5678;
    #1 chk("noise_inst_ok", inst_data_ok, 0); chk("noise_data_ok", data_data_ok, 0);
    chk("noise_rdata", data_rdata, 0);
    tick();
    mem_data_ok = 0; mem_addr_ok = 0;
    #1 chk("noise_busy", arb_busy, 0);
    tick();

    // Flushed fetch is discarded, the next completes
    inst_req = 1; inst_addr = 32'hBFC0_0004;
    tick();
    mem_addr_ok = 1;
    tick();
    inst_req = 0; mem_addr_ok = 0; inst_cancel = 1;
    tick();
    inst_cancel = 0; mem_data_ok = 1; mem_rdata = 32'hDEAD_BEEF;
    #1 chk("flush_data_ok", inst_data_ok, 0); chk("flush_rdata", inst_rdata, 0);
    tick();
    mem_data_ok = 0; inst_req = 1; inst_addr = 32'hBFC0_0008;
    tick();
    mem_addr_ok = 1;
    tick();
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'hAAAA_5555;
    #1 chk("after_flush_ok", inst_data_ok, 1); chk("after_flush_rdata", inst_rdata, 32'hAAAA_5555);
    tick();
    mem_data_ok = 0;
    tick();

    // Starvation: data wins four contests, then the held fetch wins
    data_req = 1; data_wr = 1; data_size = 2; data_wstrb = 4'hF;
    data_addr = 32'h8000_1000; data_wdata = 32'h1122_3344;
    inst_req = 1; inst_addr = 32'hBFC0_0010;
    tick();
    for (int k = 0; k < 4; k++) begin
      #1 chk("starve_data_wr", mem_wr, 1);
      chk("starve_data_addr", mem_addr, 32'h8000_1000 + 32'(k * 4));
      mem_addr_ok = 1;
      tick();
      mem_addr_ok = 0;
      if (k < 3) data_addr = 32'h8000_1000 + 32'((k + 1) * 4);
      else begin
        data_addr = 32'h8000_2002; data_size = 2'd1; data_wstrb = 4'b0011;
        data_wdata = 32'h0000_BEEF;
      end
      mem_data_ok = 1; mem_rdata = 32'(k);
      #1 chk("starve_data_ok", data_data_ok, 1);
      tick();
      mem_data_ok = 0;
    end
    #1 chk("starve_fetch_wr", mem_wr, 0); chk("starve_fetch_addr", mem_addr, 32'hBFC0_0010);
    chk("starve_fetch_size", mem_size, 2);
    mem_addr_ok = 1;
    tick();
    inst_addr = 32'hBFC0_0014; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h0BAD_F00D;
    #1 chk("starve_fetch_ok", inst_data_ok, 1);
    tick();

    // Counter cleared: store wins, then fetch follows without a bubble
    mem_data_ok = 0;
    #1 chk("store_wstrb", mem_wstrb, 4'b0011); chk("store_size", mem_size, 1);
    chk("store_addr", mem_addr, 32'h8000_2002); chk("store_wdata", mem_wdata, 32'h0000_BEEF);
    mem_addr_ok = 1;
    tick();
    data_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 0;
    #1 chk("store_done", data_data_ok, 1);
    tick();
    mem_data_ok = 0;
    #1 chk("b2b_no_bubble", mem_req, 1); chk("b2b_addr", mem_addr, 32'hBFC0_0014);

    // Asynchronous reset in ADDR, then pending fetch is granted first
    rst = 0;
    #1 chk("rst_mid_req", mem_req, 0); chk("rst_mid_busy", arb_busy, 0);
    tick();
    tick();
    rst = 1;
    tick();
    #1 chk("rst_regrant_req", mem_req, 1); chk("rst_regrant_addr", mem_addr, 32'hBFC0_0014);
    mem_addr_ok = 1;
    tick();
    inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
    tick();
    mem_data_ok = 0;
    tick();

    // Randomized traffic with noisy handshakes and flushes
    for (int c = 0; c < 3000; c++) begin
      if (!inst_req || acc_i) begin
        inst_req = ($urandom_range(0, 9) < 6);
        inst_addr = {$urandom, 2'b00} >> 2 << 2;
      end
      if (!data_req || acc_d) begin
        data_req = ($urandom_range(0, 9) < 6);
        data_wr = 1'($urandom);
        data_size = 2'($urandom_range(0, 2));
        data_wstrb = 4'($urandom);
        data_addr = $urandom;
        data_wdata = $urandom;
      end
      mem_addr_ok = ($urandom_range(0, 2) == 0);
      mem_data_ok = ($urandom_range(0, 2) == 0);
      mem_rdata = $urandom;
      inst_cancel = !mem_data_ok && ($urandom_range(0, 7) == 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
